// File: rtl/tomasulo_pkg.sv
// Shared constants for the Tomasulo core: datapath widths and the opcode field
// that marks end of program.
package tomasulo_pkg;

    localparam int unsigned INSTR_W    = 16;
    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned OPCODE_MSB = 15;
    localparam int unsigned OPCODE_LSB = 12;
    localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

    localparam logic [OPCODE_W-1:0] HALT_OP = 4'b1111;

endpackage

// File: rtl/iq_storage.sv
// Entry array for the instruction queue: one synchronous write port and one
// asynchronous read port; contents are never reset.
module iq_storage #(
    parameter int unsigned WIDTH = 21,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_queue.sv
// Fetch buffer between instruction memory and issue: captures {pc, instr} each
// posedge, requests a PC advance per accepted word, stops on HALT, flushes on redirect.
module instruction_queue #(
    parameter int unsigned INSTR_W = tomasulo_pkg::INSTR_W,
    parameter int unsigned ADDR_W  = tomasulo_pkg::ADDR_W,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                   CLK,
    input  logic                   CLR,
    input  logic [INSTR_W-1:0]     instr_in,
    input  logic [ADDR_W-1:0]      pc_in,
    output logic                   incr,
    input  logic                   flush,
    input  logic                   issue_ready,
    output logic                   issue_valid,
    output logic [INSTR_W-1:0]     issue_instr,
    output logic [ADDR_W-1:0]      issue_pc,
    output logic [$clog2(DEPTH):0] count,
    output logic                   halted
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OP_W  = tomasulo_pkg::OPCODE_W;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             halted_q, halted_d;
    logic             incr_q, incr_d;
    logic             full, wr_fire, rd_fire, is_halt;
    logic [ADDR_W+INSTR_W-1:0] rd_entry;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign wr_fire = !full && !halted_q && !flush;
    assign rd_fire = (count_q != '0) && issue_ready && !flush;
    assign is_halt = (instr_in[INSTR_W-1 -: OP_W] == tomasulo_pkg::HALT_OP);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        halted_d = halted_q;
        incr_d   = 1'b0;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            halted_d = 1'b0;
        end else begin
            if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({wr_fire, rd_fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (wr_fire && is_halt) halted_d = 1'b1;
            // One PC step per accepted word, so a full queue never re-fetches.
            incr_d = wr_fire;
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
            incr_q   <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            halted_q <= halted_d;
            incr_q   <= incr_d;
        end
    end

    iq_storage #(
        .WIDTH (ADDR_W + INSTR_W),
        .DEPTH (DEPTH)
    ) u_storage (
        .CLK   (CLK),
        .we    (wr_fire),
        .waddr (wr_ptr_q),
        .wdata ({pc_in, instr_in}),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    assign issue_valid = (count_q != '0);
    assign issue_pc    = rd_entry[ADDR_W+INSTR_W-1 -: ADDR_W];
    assign issue_instr = rd_entry[INSTR_W-1:0];
    assign count       = count_q;
    assign halted      = halted_q;
    assign incr        = incr_q;

endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue: an environment PC driven by incr, a
// behavioural occupancy model, and a scoreboard of fetched words in program order.
module tb_instruction_queue;

    localparam int DEPTH = 4;

    logic        CLK;
    logic        CLR;
    logic [15:0] instr_in;
    logic [4:0]  pc;
    logic        incr;
    logic        flush;
    logic        issue_ready;
    logic        issue_valid;
    logic [15:0] issue_instr;
    logic [4:0]  issue_pc;
    logic [2:0]  count;
    logic        halted;

    logic [15:0] mem [32];
    logic [20:0] sb [$];
    int          m_count;
    bit          m_halted;
    bit          m_incr;
    int          n_cmp;
    int          n_fail;

    instruction_queue #(
        .INSTR_W (16),
        .ADDR_W  (5),
        .DEPTH   (DEPTH)
    ) dut (
        .CLK         (CLK),
        .CLR         (CLR),
        .instr_in    (instr_in),
        .pc_in       (pc),
        .incr        (incr),
        .flush       (flush),
        .issue_ready (issue_ready),
        .issue_valid (issue_valid),
        .issue_instr (issue_instr),
        .issue_pc    (issue_pc),
        .count       (count),
        .halted      (halted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign instr_in = mem[pc];

    // Program counter: advances on negedge when incr is seen.
    always @(negedge CLK) begin
        if (CLR) pc <= '0;
        else if (incr) pc <= pc + 5'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count  = 0;
        m_halted = 1'b0;
        m_incr   = 1'b0;
        sb.delete();
    endtask

    // One clock: predict, compare issued word before the edge, state after it.
    task automatic step();
        bit          m_wr, m_rd, m_hl;
        logic [20:0] e;
        @(negedge CLK);
        #2;
        m_wr = (m_count < DEPTH) && !m_halted && !flush;
        m_rd = (m_count != 0) && issue_ready && !flush;
        m_hl = m_wr && (mem[pc][15:12] == 4'hF);
        if (m_rd) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("issue_pc", 32'(issue_pc), 32'(e[20:16]));
                check("issue_instr", 32'(issue_instr), 32'(e[15:0]));
            end
        end
        if (flush) sb.delete();
        if (m_wr) sb.push_back({pc, mem[pc]});
        @(posedge CLK);
        #1;
        if (flush) begin
            m_count  = 0;
            m_halted = 1'b0;
            m_incr   = 1'b0;
        end else begin
            m_count = m_count + int'(m_wr) - int'(m_rd);
            if (m_hl) m_halted = 1'b1;
            m_incr = m_wr;
        end
        check("count", 32'(count), 32'(m_count));
        check("issue_valid", 32'(issue_valid), 32'(m_count != 0));
        check("incr", 32'(incr), 32'(m_incr));
        check("halted", 32'(halted), 32'(m_halted));
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        for (int a = 0; a < 32; a++) mem[a] = 16'(32'h100 + a);
        mem[5] = 16'hF105;
        pc          = '0;
        CLR         = 1'b1;
        flush       = 1'b0;
        issue_ready = 1'b0;
        model_reset();
        #3;
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(issue_valid), 32'd0);
        check("rst_incr", 32'(incr), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        #4;
        CLR = 1'b0;

        // Streaming with issue always ready: occupancy never exceeds one.
        issue_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stream_count_le1", 32'(count <= 3'd1), 32'd1);
        end

        // Asynchronous clear between edges.
        @(negedge CLK);
        #2;
        CLR = 1'b1;
        #1;
        check("aclr_count", 32'(count), 32'd0);
        check("aclr_incr", 32'(incr), 32'd0);
        check("aclr_valid", 32'(issue_valid), 32'd0);
        pc = '0;
        model_reset();
        @(posedge CLK);
        #1;
        CLR = 1'b0;

        // Fill with issue stalled: four words taken, PC holds at 4.
        issue_ready = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("fill_count", 32'(count), 32'd4);
        check("fill_pc_hold", 32'(pc), 32'd4);

        // Drain in order; HALT at address 5 stops fetch with PC at 6.
        issue_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("halt_pc", 32'(pc), 32'd6);
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_drained", 32'(sb.size()), 32'd0);

        // Flush clears halt and redirects to 8; then build up three entries.
        flush = 1'b1;
        step();
        flush = 1'b0;
        pc    = 5'd8;
        issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("pre_flush_count", 32'(count), 32'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        pc    = 5'd16;
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(issue_valid), 32'd0);
        check("flush_halted", 32'(halted), 32'd0);

        // Resume at 16, then hold occupancy at two while pointers wrap.
        issue_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        issue_ready = 1'b0;
        step();
        check("hold2_start", 32'(count), 32'd2);
        issue_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("hold2_count", 32'(count), 32'd2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
